// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
// Holds in-flight BTB predictions from fetch in a small circular queue.
// When execute resolves the oldest instruction, the head prediction is checked
// against the actual outcome. The unit raises a registered fetch redirect on a
// mispredict and a registered BTB write for every taken branch.
//
// Handshake: a prediction is accepted on a rising edge only when
// i_pred_valid && o_pred_ready. o_pred_ready depends only on registered
// occupancy, so a full queue refuses a push even if a pop happens in the same
// cycle. i_res_valid has no ready: execute resolves in program order and the
// unit must take it. A resolve seen while the queue is empty sets o_err.
module branch_resolve_unit #(
    parameter int ADDR_WIDTH = 64,
    parameter int DEPTH      = 4
) (
    input  logic                       i_clk,
    input  logic                       i_arst,
    input  logic                       i_pred_valid,
    input  logic [ADDR_WIDTH-1:0]      i_pred_pc,
    input  logic                       i_pred_hit,
    input  logic [ADDR_WIDTH-1:0]      i_pred_target,
    output logic                       o_pred_ready,
    input  logic                       i_res_valid,
    input  logic                       i_res_taken,
    input  logic [ADDR_WIDTH-1:0]      i_res_target,
    output logic                       o_redirect,
    output logic [ADDR_WIDTH-1:0]      o_redirect_addr,
    output logic                       o_btb_update,
    output logic [ADDR_WIDTH-1:0]      o_btb_instr_addr,
    output logic [ADDR_WIDTH-1:0]      o_btb_target_addr,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [CNT_W-1:0]      CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0]      PTR_ONE  = PTR_W'(1);
    localparam logic [ADDR_WIDTH-1:0] INSTR_SZ = ADDR_WIDTH'(4);

    // Prediction storage; payload needs no reset because occupancy guards every read.
    logic [ADDR_WIDTH-1:0] pc_mem  [DEPTH];
    logic                  hit_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] tgt_mem [DEPTH];

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    logic                  push;
    logic                  pop;
    logic                  mispredict;
    logic                  flush;
    logic [ADDR_WIDTH-1:0] head_pc;
    logic                  head_hit;
    logic [ADDR_WIDTH-1:0] head_tgt;

    assign o_pred_ready = (count != CNT_FULL);
    assign o_count      = count;

    // Head lookup and prediction-versus-outcome compare for the resolving instruction.
    always_comb begin
        head_pc    = pc_mem[rd_ptr];
        head_hit   = hit_mem[rd_ptr];
        head_tgt   = tgt_mem[rd_ptr];
        push       = i_pred_valid && o_pred_ready;
        pop        = i_res_valid && (count != '0);
        mispredict = (head_hit != i_res_taken) ||
                     (head_hit && i_res_taken && (head_tgt != i_res_target));
        flush      = pop && mispredict;
    end

    // Write accepted predictions at the tail; a flushing cycle drops the wrong-path push.
    always_ff @(posedge i_clk) begin
        if (push && !flush) begin
            pc_mem[wr_ptr]  <= i_pred_pc;
            hit_mem[wr_ptr] <= i_pred_hit;
            tgt_mem[wr_ptr] <= i_pred_target;
        end
    end

    // Queue pointers and occupancy; a mispredict empties the queue outright.
    always_ff @(posedge i_clk) begin
        if (i_arst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Registered redirect and BTB write pulses, one cycle after the resolve edge.
    always_ff @(posedge i_clk) begin
        if (i_arst) begin
            o_redirect        <= 1'b0;
            o_redirect_addr   <= '0;
            o_btb_update      <= 1'b0;
            o_btb_instr_addr  <= '0;
            o_btb_target_addr <= '0;
        end else begin
            o_redirect   <= flush;
            o_btb_update <= pop && i_res_taken;
            if (flush) begin
                o_redirect_addr <= i_res_taken ? i_res_target : (head_pc + INSTR_SZ);
            end
            if (pop && i_res_taken) begin
                o_btb_instr_addr  <= head_pc;
                o_btb_target_addr <= i_res_target;
            end
        end
    end

    // Sticky error for a resolve that arrives with nothing in flight.
    always_ff @(posedge i_clk) begin
        if (i_arst) begin
            o_err <= 1'b0;
        end else if (i_res_valid && (count == '0)) begin
            o_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit (ADDR_WIDTH=64, DEPTH=4).
// Expected redirect/BTB pulses are queued when a resolve is issued; a monitor
// pops them whenever the DUT raises a pulse.
module tb_branch_resolve_unit;

    localparam int AW = 64;
    localparam int EW = 2 + 3 * AW;

    logic          clk;
    logic          arst;
    logic          pred_valid;
    logic [AW-1:0] pred_pc;
    logic          pred_hit;
    logic [AW-1:0] pred_target;
    logic          pred_ready;
    logic          res_valid;
    logic          res_taken;
    logic [AW-1:0] res_target;
    logic          redirect;
    logic [AW-1:0] redirect_addr;
    logic          btb_update;
    logic [AW-1:0] btb_instr_addr;
    logic [AW-1:0] btb_target_addr;
    logic [2:0]    count;
    logic          err;

    int vectors     = 0;
    int miscompares = 0;

    logic [EW-1:0] exp_q[$];

    branch_resolve_unit #(.ADDR_WIDTH(AW), .DEPTH(4)) dut (
        .i_clk             (clk),
        .i_arst            (arst),
        .i_pred_valid      (pred_valid),
        .i_pred_pc         (pred_pc),
        .i_pred_hit        (pred_hit),
        .i_pred_target     (pred_target),
        .o_pred_ready      (pred_ready),
        .i_res_valid       (res_valid),
        .i_res_taken       (res_taken),
        .i_res_target      (res_target),
        .o_redirect        (redirect),
        .o_redirect_addr   (redirect_addr),
        .o_btb_update      (btb_update),
        .o_btb_instr_addr  (btb_instr_addr),
        .o_btb_target_addr (btb_target_addr),
        .o_count           (count),
        .o_err             (err)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock of stimulus; inputs return to idle afterwards.
    task automatic cyc(input logic pv, input logic [AW-1:0] ppc, input logic phit,
                       input logic [AW-1:0] ptgt, input logic rv, input logic rt,
                       input logic [AW-1:0] rtgt);
        pred_valid  = pv;
        pred_pc     = ppc;
        pred_hit    = phit;
        pred_target = ptgt;
        res_valid   = rv;
        res_taken   = rt;
        res_target  = rtgt;
        @(posedge clk);
        #1;
        pred_valid = 1'b0;
        res_valid  = 1'b0;
    endtask

    task automatic push(input logic [AW-1:0] pc, input logic hit, input logic [AW-1:0] tgt);
        cyc(1'b1, pc, hit, tgt, 1'b0, 1'b0, '0);
    endtask

    task automatic resolve(input logic taken, input logic [AW-1:0] tgt);
        cyc(1'b0, '0, 1'b0, '0, 1'b1, taken, tgt);
    endtask

    task automatic idle();
        cyc(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0);
    endtask

    task automatic expect_out(input logic r, input logic [AW-1:0] raddr, input logic b,
                              input logic [AW-1:0] iaddr, input logic [AW-1:0] taddr);
        exp_q.push_back({r, b, raddr, iaddr, taddr});
    endtask

    // Scoreboard monitor: every pulse must match the oldest expected response.
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (redirect || btb_update) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL spurious_pulse: got redirect=%0b btb_update=%0b expected no pulse",
                         redirect, btb_update);
            end else begin
                e = exp_q.pop_front();
                check("mon_redirect", {63'b0, redirect}, {63'b0, e[EW-1]});
                check("mon_btb_update", {63'b0, btb_update}, {63'b0, e[EW-2]});
                if (e[EW-1]) check("mon_redirect_addr", redirect_addr, e[3*AW-1:2*AW]);
                if (e[EW-2]) begin
                    check("mon_btb_instr_addr", btb_instr_addr, e[2*AW-1:AW]);
                    check("mon_btb_target_addr", btb_target_addr, e[AW-1:0]);
                end
            end
        end
    end

    initial begin
        arst = 1'b1;
        pred_valid = 1'b0; pred_pc = '0; pred_hit = 1'b0; pred_target = '0;
        res_valid = 1'b0; res_taken = 1'b0; res_target = '0;

        // Reset state
        idle(); idle();
        arst = 1'b0;
        check("rst_count", 64'(count), 64'd0);
        check("rst_ready", 64'(pred_ready), 64'd1);
        check("rst_err", 64'(err), 64'd0);
        check("rst_redirect", 64'(redirect), 64'd0);
        check("rst_btb_update", 64'(btb_update), 64'd0);
        check("rst_redirect_addr", redirect_addr, 64'd0);
        check("rst_btb_instr", btb_instr_addr, 64'd0);
        check("rst_btb_target", btb_target_addr, 64'd0);

        // Correct taken prediction: BTB write, no redirect
        push(64'h100, 1'b1, 64'h200);
        check("one_count", 64'(count), 64'd1);
        expect_out(1'b0, '0, 1'b1, 64'h100, 64'h200);
        resolve(1'b1, 64'h200);
        check("correct_count", 64'(count), 64'd0);
        idle();
        check("pulse_drop_btb", 64'(btb_update), 64'd0);
        check("pulse_drop_redirect", 64'(redirect), 64'd0);

        // Predicted not-taken, actually taken
        push(64'h104, 1'b0, 64'h0);
        expect_out(1'b1, 64'h300, 1'b1, 64'h104, 64'h300);
        resolve(1'b1, 64'h300);
        idle();

        // Predicted taken, actually not taken: redirect to pc+4, no BTB write
        push(64'h108, 1'b1, 64'h400);
        expect_out(1'b1, 64'h10C, 1'b0, '0, '0);
        resolve(1'b0, 64'h0);
        check("nt_count", 64'(count), 64'd0);
        idle();

        // Fill to full, overflow push dropped, concurrent pop still refuses push
        push(64'h200, 1'b1, 64'h280);
        push(64'h204, 1'b0, 64'h0);
        push(64'h208, 1'b1, 64'h300);
        push(64'h20C, 1'b0, 64'h0);
        check("full_count", 64'(count), 64'd4);
        check("full_ready", 64'(pred_ready), 64'd0);
        push(64'h210, 1'b1, 64'h999);
        check("drop_count", 64'(count), 64'd4);
        expect_out(1'b0, '0, 1'b1, 64'h200, 64'h280);
        cyc(1'b1, 64'h214, 1'b1, 64'h888, 1'b1, 1'b1, 64'h280);
        check("full_pop_count", 64'(count), 64'd3);
        check("full_pop_ready", 64'(pred_ready), 64'd1);
        resolve(1'b0, 64'h0);
        check("pop_b_count", 64'(count), 64'd2);
        expect_out(1'b0, '0, 1'b1, 64'h208, 64'h300);
        resolve(1'b1, 64'h300);
        push(64'h220, 1'b0, 64'h0);
        check("wrap_count", 64'(count), 64'd2);
        resolve(1'b0, 64'h0);
        expect_out(1'b1, 64'h500, 1'b1, 64'h220, 64'h500);
        resolve(1'b1, 64'h500);
        check("wrap_end_count", 64'(count), 64'd0);
        idle();

        // Target mispredict with concurrent push flushes the queue
        push(64'h300, 1'b1, 64'h380);
        push(64'h304, 1'b0, 64'h0);
        push(64'h308, 1'b0, 64'h0);
        check("three_count", 64'(count), 64'd3);
        expect_out(1'b1, 64'h390, 1'b1, 64'h300, 64'h390);
        cyc(1'b1, 64'h30C, 1'b0, 64'h0, 1'b1, 1'b1, 64'h390);
        check("flush_count", 64'(count), 64'd0);
        check("flush_ready", 64'(pred_ready), 64'd1);
        push(64'h400, 1'b1, 64'h480);
        expect_out(1'b0, '0, 1'b1, 64'h400, 64'h480);
        resolve(1'b1, 64'h480);
        check("post_flush_count", 64'(count), 64'd0);

        // Back-to-back resolves give back-to-back pulses
        push(64'h500, 1'b1, 64'h600);
        push(64'h504, 1'b1, 64'h700);
        expect_out(1'b0, '0, 1'b1, 64'h500, 64'h600);
        resolve(1'b1, 64'h600);
        expect_out(1'b0, '0, 1'b1, 64'h504, 64'h700);
        resolve(1'b1, 64'h700);
        idle();

        // pc+4 wraps at 2^64
        push(64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 64'h10);
        expect_out(1'b1, 64'h0, 1'b0, '0, '0);
        resolve(1'b0, 64'h0);
        idle();

        // Resolve on empty queue: sticky error, no pulses
        resolve(1'b1, 64'h999);
        check("empty_err", 64'(err), 64'd1);
        check("empty_redirect", 64'(redirect), 64'd0);
        check("empty_btb", 64'(btb_update), 64'd0);
        idle(); idle();
        check("err_sticky", 64'(err), 64'd1);

        // Mid-stream reset discards entries and clears outputs
        push(64'h700, 1'b0, 64'h0);
        push(64'h704, 1'b1, 64'h780);
        arst = 1'b1;
        resolve(1'b1, 64'h777);
        arst = 1'b0;
        check("mrst_count", 64'(count), 64'd0);
        check("mrst_err", 64'(err), 64'd0);
        check("mrst_redirect", 64'(redirect), 64'd0);
        check("mrst_btb", 64'(btb_update), 64'd0);
        check("mrst_redirect_addr", redirect_addr, 64'd0);
        check("mrst_btb_instr", btb_instr_addr, 64'd0);
        check("mrst_btb_target", btb_target_addr, 64'd0);
        push(64'h604, 1'b1, 64'h650);
        expect_out(1'b0, '0, 1'b1, 64'h604, 64'h650);
        resolve(1'b1, 64'h650);
        idle(); idle(); idle();

        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
